fft_bfly_scheduler: RTL and testbench

//  Sequences one shared combinational radix-2 butterfly unit through the 4 butterflies
//  of a 4-point DIT FFT (2 stages x 2 butterflies). Sits between the top-level system FSM
//  (start/done) and the butterfly unit; holds complex work registers and result registers.

---
 rtl/fft_bfly_scheduler.sv | 151 +++++++++++++++
 tb/tb_fft_bfly_scheduler.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fft_bfly_scheduler.sv
// Drives one shared radix-2 butterfly through the four butterflies of a 4-point DIT FFT.
// Holds the sample and work registers and commits all four results to freq_* together.
module fft_bfly_scheduler #(
  parameter int unsigned DATA_W = 16,
  parameter bit          SCALE  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  start,
  input  logic [DATA_W-1:0]     sample0_in,
  input  logic [DATA_W-1:0]     sample1_in,
  input  logic [DATA_W-1:0]     sample2_in,
  input  logic [DATA_W-1:0]     sample3_in,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_W-1:0]     bf_a_re,
  output logic [DATA_W-1:0]     bf_a_im,
  output logic [DATA_W-1:0]     bf_b_re,
  output logic [DATA_W-1:0]     bf_b_im,
  input  logic [DATA_W-1:0]     bf_sum_re,
  input  logic [DATA_W-1:0]     bf_sum_im,
  input  logic [DATA_W-1:0]     bf_diff_re,
  input  logic [DATA_W-1:0]     bf_diff_im,
  output logic [4*DATA_W-1:0]   freq_re,
  output logic [4*DATA_W-1:0]   freq_im
);

  typedef enum logic [2:0] {StIdle, StS1a, StS1b, StS2a, StS2b, StDone} state_e;

  state_e state;

  logic signed [DATA_W-1:0] x0, x1, x2, x3;
  logic signed [DATA_W-1:0] w0_re, w0_im, w1_re, w1_im;
  logic signed [DATA_W-1:0] w2_re, w2_im, w3_re, w3_im;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= StIdle;
      busy    <= 1'b0;
      done    <= 1'b0;
      x0      <= '0;
      x1      <= '0;
      x2      <= '0;
      x3      <= '0;
      w0_re   <= '0;
      w0_im   <= '0;
      w1_re   <= '0;
      w1_im   <= '0;
      w2_re   <= '0;
      w2_im   <= '0;
      w3_re   <= '0;
      w3_im   <= '0;
      freq_re <= '0;
      freq_im <= '0;
    end else if (en) begin
      case (state)
        StIdle: begin
          if (start) begin
            x0    <= sample0_in;
            x1    <= sample1_in;
            x2    <= sample2_in;
            x3    <= sample3_in;
            busy  <= 1'b1;
            state <= StS1a;
          end
        end
        StS1a: begin
          w0_re <= bf_sum_re;
          w0_im <= bf_sum_im;
          w1_re <= bf_diff_re;
          w1_im <= bf_diff_im;
          state <= StS1b;
        end
        StS1b: begin
          w2_re <= bf_sum_re;
          w2_im <= bf_sum_im;
          w3_re <= bf_diff_re;
          w3_im <= bf_diff_im;
          state <= StS2a;
        end
        StS2a: begin
          // w0/w2 are dead after this butterfly, so they park X0/X2 until commit
          w0_re <= bf_sum_re;
          w0_im <= bf_sum_im;
          w2_re <= bf_diff_re;
          w2_im <= bf_diff_im;
          state <= StS2b;
        end
        StS2b: begin
          freq_re <= {bf_diff_re, w2_re, bf_sum_re, w0_re};
          freq_im <= {bf_diff_im, w2_im, bf_sum_im, w0_im};
          done    <= 1'b1;
          state   <= StDone;
        end
        StDone: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= StIdle;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= StIdle;
        end
      endcase
    end
  end

  logic signed [DATA_W-1:0] op_a_re, op_a_im, op_b_re, op_b_im;
  logic signed [DATA_W-1:0] w3_re_neg;

  assign w3_re_neg = -w3_re;

  always_comb begin
    op_a_re = '0;
    op_a_im = '0;
    op_b_re = '0;
    op_b_im = '0;
    case (state)
      StS1a: begin
        op_a_re = x0;
        op_b_re = x2;
      end
      StS1b: begin
        op_a_re = x1;
        op_b_re = x3;
      end
      StS2a: begin
        op_a_re = w0_re;
        op_a_im = w0_im;
        op_b_re = w2_re;
        op_b_im = w2_im;
      end
      StS2b: begin
        // B = -j * w3
        op_a_re = w1_re;
        op_a_im = w1_im;
        op_b_re = w3_im;
        op_b_im = w3_re_neg;
      end
      default: ;
    endcase
  end

  assign bf_a_re = SCALE ? (op_a_re >>> 1) : op_a_re;
  assign bf_a_im = SCALE ? (op_a_im >>> 1) : op_a_im;
  assign bf_b_re = SCALE ? (op_b_re >>> 1) : op_b_re;
  assign bf_b_im = SCALE ? (op_b_im >>> 1) : op_b_im;

endmodule

// File: tb/tb_fft_bfly_scheduler.sv
// Bench for fft_bfly_scheduler: unscaled and scaled instances share control and samples,
// each fed by a wrap-around butterfly, results checked against a stage-level FFT model.
module tb_fft_bfly_scheduler;

  logic clk = 1'b0;
  logic rst, en, start;
  logic [15:0] sample0, sample1, sample2, sample3;

  logic busy0, done0, busy1, done1;
  logic [15:0] a0_re, a0_im, b0_re, b0_im, a1_re, a1_im, b1_re, b1_im;
  logic [15:0] s0_re, s0_im, d0_re, d0_im, s1_re, s1_im, d1_re, d1_im;
  logic [63:0] fre0, fim0, fre1, fim1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign s0_re = a0_re + b0_re;
  assign s0_im = a0_im + b0_im;
  assign d0_re = a0_re - b0_re;
  assign d0_im = a0_im - b0_im;
  assign s1_re = a1_re + b1_re;
  assign s1_im = a1_im + b1_im;
  assign d1_re = a1_re - b1_re;
  assign d1_im = a1_im - b1_im;

  fft_bfly_scheduler #(.DATA_W(16), .SCALE(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .en(en), .start(start),
    .sample0_in(sample0), .sample1_in(sample1), .sample2_in(sample2), .sample3_in(sample3),
    .busy(busy0), .done(done0),
    .bf_a_re(a0_re), .bf_a_im(a0_im), .bf_b_re(b0_re), .bf_b_im(b0_im),
    .bf_sum_re(s0_re), .bf_sum_im(s0_im), .bf_diff_re(d0_re), .bf_diff_im(d0_im),
    .freq_re(fre0), .freq_im(fim0)
  );

  fft_bfly_scheduler #(.DATA_W(16), .SCALE(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .start(start),
    .sample0_in(sample0), .sample1_in(sample1), .sample2_in(sample2), .sample3_in(sample3),
    .busy(busy1), .done(done1),
    .bf_a_re(a1_re), .bf_a_im(a1_im), .bf_b_re(b1_re), .bf_b_im(b1_im),
    .bf_sum_re(s1_re), .bf_sum_im(s1_im), .bf_diff_re(d1_re), .bf_diff_im(d1_im),
    .freq_re(fre1), .freq_im(fim1)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic signed [15:0] sh(input logic signed [15:0] v, input bit s);
    return s ? (v >>> 1) : v;
  endfunction

  // Two radix-2 stages on real inputs; stage-2 odd butterfly uses -j*w3.
  function automatic void ref_fft(input logic signed [15:0] x0, x1, x2, x3, input bit s,
                                  output logic [63:0] fre, output logic [63:0] fim);
    logic signed [15:0] w0, w1, w2, w3, nw3, bi, y0, y2, y1r;
    w0  = sh(x0, s) + sh(x2, s);
    w1  = sh(x0, s) - sh(x2, s);
    w2  = sh(x1, s) + sh(x3, s);
    w3  = sh(x1, s) - sh(x3, s);
    y0  = sh(w0, s) + sh(w2, s);
    y2  = sh(w0, s) - sh(w2, s);
    nw3 = -w3;
    bi  = sh(nw3, s);
    y1r = sh(w1, s);
    fre = {y1r, y2, y1r, y0};
    fim = {-bi, 16'd0, bi, 16'd0};
  endfunction

  task automatic check_freq(input logic [15:0] a, b, c, d);
    logic [63:0] er, ei;
    ref_fft(a, b, c, d, 1'b0, er, ei);
    chk("freq_re_s0", fre0, er);
    chk("freq_im_s0", fim0, ei);
    ref_fft(a, b, c, d, 1'b1, er, ei);
    chk("freq_re_s1", fre1, er);
    chk("freq_im_s1", fim1, ei);
  endtask

  // Start held high through DONE to show it is ignored while busy.
  task automatic do_fft(input logic [15:0] a, b, c, d);
    sample0 = a; sample1 = b; sample2 = c; sample3 = d;
    start = 1'b1;
    en = 1'b1;
    tick();
    chk("busy_after_start", 64'(busy0), 64'd1);
    chk("s1a_op_a", {48'd0, a0_re}, {48'd0, a});
    chk("s1a_op_b", {48'd0, b0_re}, {48'd0, c});
    sample0 = 16'($urandom); sample1 = 16'($urandom);
    sample2 = 16'($urandom); sample3 = 16'($urandom);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("done0_timing", 64'(done0), 64'(k == 4));
      chk("done1_timing", 64'(done1), 64'(k == 4));
    end
    chk("busy_idle_after", 64'(busy0), 64'd0);
    start = 1'b0;
    check_freq(a, b, c, d);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; start = 1'b0;
    sample0 = 16'd0; sample1 = 16'd0; sample2 = 16'd0; sample3 = 16'd0;
    tick();
    tick();
    chk("rst_busy", {62'd0, busy0, busy1}, 64'd0);
    chk("rst_done", {62'd0, done0, done1}, 64'd0);
    chk("rst_freq0", fre0 | fim0, 64'd0);
    chk("rst_freq1", fre1 | fim1, 64'd0);
    chk("rst_ops", {a0_re, a0_im, b0_re, b0_im}, 64'd0);
    rst = 1'b0;
    tick();

    do_fft(16'd1, 16'd0, 16'd0, 16'd0);
    chk("impulse_re", fre0, 64'h0001_0001_0001_0001);
    chk("impulse_im", fim0, 64'd0);
    chk("idle_ops", {a0_re, a0_im, b0_re, b0_im}, 64'd0);

    do_fft(16'd1, 16'd2, 16'd3, 16'd4);
    chk("ramp_re", fre0, 64'hfffe_fffe_fffe_000a);
    chk("ramp_im", fim0, 64'hfffe_0000_0002_0000);

    do_fft(16'd100, 16'd100, 16'd100, 16'd100);
    chk("scaled_dc_re", fre1, 64'h0000_0000_0000_0064);
    chk("scaled_dc_im", fim1, 64'd0);

    do_fft(16'd32767, 16'd32767, 16'd0, 16'd0);
    chk("wrap_re", fre0, 64'h7fff_0000_7fff_fffe);
    chk("wrap_im", fim0, 64'h7fff_0000_8001_0000);

    for (int i = 0; i < 8; i++) begin
      do_fft(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    end

    // Stall three cycles in S2A with start pulses, then stall once in DONE.
    sample0 = 16'd5; sample1 = 16'hfff0; sample2 = 16'd7; sample3 = 16'h8000;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      start = k[0] ? 1'b0 : 1'b1;
      tick();
      chk("stall_busy", 64'(busy0), 64'd1);
      chk("stall_done", 64'(done0), 64'd0);
    end
    en = 1'b1;
    start = 1'b0;
    tick();
    chk("stall_t6_done", 64'(done0), 64'd0);
    tick();
    chk("stall_t7_done", {62'd0, done0, done1}, 64'd3);
    check_freq(16'd5, 16'hfff0, 16'd7, 16'h8000);
    en = 1'b0;
    tick();
    chk("done_held_en0", 64'(done0), 64'd1);
    en = 1'b1;
    tick();
    chk("done_cleared", {62'd0, done0, busy0}, 64'd0);

    // Reset mid-transform aborts it and clears committed results.
    sample0 = 16'd9; sample1 = 16'd8; sample2 = 16'd7; sample3 = 16'd6;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", {62'd0, busy0, busy1}, 64'd0);
    chk("abort_freq0", fre0 | fim0, 64'd0);
    chk("abort_freq1", fre1 | fim1, 64'd0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("abort_no_done", {62'd0, done0, done1}, 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
